// File: rtl/memoria_corrientes_pkg.sv
// Shared constants and setpoint function for the current-setpoint lookup path.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a (no interfaces declared here).
package memoria_corrientes_pkg;

    // Default geometry and step of the setpoint table.
    localparam int unsigned CORR_ADDR_W = 4;
    localparam int unsigned CORR_DATA_W = 10;
    localparam int unsigned CORR_STEP   = 68;

    // Saturated setpoint for code k: k*step clipped to the all-ones value of a
    // data_w-bit word. The product is formed at 64 bits, so no intermediate
    // wrap can hide an overflow for any table geometry this block supports.
    function automatic int unsigned corr_setpoint(
        input int unsigned k,
        input int unsigned step   = CORR_STEP,
        input int unsigned data_w = CORR_DATA_W
    );
        longint unsigned prod;
        longint unsigned max_val;
        prod    = 64'(k) * 64'(step);
        max_val = (64'd1 << data_w) - 64'd1;
        if (prod > max_val) begin
            return 32'(max_val);
        end
        return 32'(prod);
    endfunction

endpackage

// File: rtl/memoria_corrientes_corr_rom.sv
// Combinational setpoint table: 2**ADDR_W entries of DATA_W bits, entry k = sat(k*STEP).
// Latency: 0 cycles (pure combinational decode).
// Backpressure: none; the table is read every cycle.
module memoria_corrientes_corr_rom
    import memoria_corrientes_pkg::*;
#(
    parameter int unsigned ADDR_W = CORR_ADDR_W,
    parameter int unsigned DATA_W = CORR_DATA_W,
    parameter int unsigned STEP   = CORR_STEP
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] dat_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Full decode of every code; an unmatched (X/Z) code falls through to 0
    // rather than propagating an unknown downstream.
    always_comb begin
        dat_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (addr_i == ADDR_W'(k)) begin
                dat_o = DATA_W'(corr_setpoint(k, STEP, DATA_W));
            end
        end
    end

endmodule

// File: rtl/memoria_corrientes.sv
// Current-setpoint lookup: registers table[corriente] onto I every rising clk edge.
// Latency: 1 cycle from code sample to I; rst low clears I to 0 asynchronously.
// Backpressure: none; no handshake or enable, the lookup runs every cycle.
module memoria_corrientes
    import memoria_corrientes_pkg::*;
#(
    parameter int unsigned ADDR_W = CORR_ADDR_W,
    parameter int unsigned DATA_W = CORR_DATA_W,
    parameter int unsigned STEP   = CORR_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] corriente,
    output logic [DATA_W-1:0] I
);

    logic [DATA_W-1:0] setpoint_d;
    logic [DATA_W-1:0] setpoint_q;

    memoria_corrientes_corr_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .STEP   (STEP)
    ) u_rom (
        .addr_i (corriente),
        .dat_o  (setpoint_d)
    );

    // Output register; rst (active-low) drops the setpoint to 0 at once so no
    // stale current target survives a reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            setpoint_q <= '0;
        end else begin
            setpoint_q <= setpoint_d;
        end
    end

    assign I = setpoint_q;

endmodule

// File: tb/tb_memoria_corrientes.sv
module tb_memoria_corrientes;
    import memoria_corrientes_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] corriente;
    logic [9:0] I;
    logic [3:0] corriente80;
    logic [9:0] I80;

    int n_checks = 0;
    int n_err    = 0;

    // Hand-computed tables: k*68, and k*80 saturating at 1023 from code 13 on.
    int unsigned exp68 [16] = '{0, 68, 136, 204, 272, 340, 408, 476,
                                544, 612, 680, 748, 816, 884, 952, 1020};
    int unsigned exp80 [16] = '{0, 80, 160, 240, 320, 400, 480, 560,
                                640, 720, 800, 880, 960, 1023, 1023, 1023};
    int unsigned step_seq [6] = '{0, 1, 2, 3, 2, 1};

    memoria_corrientes dut (
        .clk       (clk),
        .rst       (rst),
        .corriente (corriente),
        .I         (I)
    );

    memoria_corrientes #(.STEP(80)) dut80 (
        .clk       (clk),
        .rst       (rst),
        .corriente (corriente80),
        .I         (I80)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned code;
        int unsigned prev;

        // 1. Reset held with a live code: I must stay 0.
        rst         = 1'b0;
        corriente   = 4'd5;
        corriente80 = 4'd0;
        #1;
        chk("rst_t0", 16'(I), 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold", 16'(I), 16'd0);
            chk("rst_hold80", 16'(I80), 16'd0);
        end
        #2 rst = 1'b1;
        #1;
        chk("rel_before_edge", 16'(I), 16'd0);
        tick();
        chk("rel_code5", 16'(I), 16'd340);

        // 2. Step sequence, each code held 10 cycles; new value appears one edge later.
        prev = 340;
        for (int s = 0; s < 6; s++) begin
            corriente = 4'(step_seq[s]);
            #1;
            chk("step_pre_edge", 16'(I), 16'(prev));
            tick();
            chk("step_first", 16'(I), 16'(exp68[step_seq[s]]));
            for (int c = 0; c < 9; c++) tick();
            chk("step_held", 16'(I), 16'(exp68[step_seq[s]]));
            prev = exp68[step_seq[s]];
        end

        // 3 & 5. Sweep all codes one per cycle on both step variants.
        for (int k = 0; k < 16; k++) begin
            corriente   = 4'(k);
            corriente80 = 4'(k);
            tick();
            chk("sweep68", 16'(I), 16'(exp68[k]));
            chk("sweep80", 16'(I80), 16'(exp80[k]));
        end

        // 4. Async reset mid-cycle while I=204.
        corriente = 4'd3;
        tick();
        chk("pre_rst_204", 16'(I), 16'd204);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_now", 16'(I), 16'd0);
        tick();
        chk("async_rst_hold", 16'(I), 16'd0);
        #2 rst = 1'b1;
        #1;
        chk("rel2_before_edge", 16'(I), 16'd0);
        tick();
        chk("rel2_code3", 16'(I), 16'd204);

        // 6. Random codes under two seeds against the package function.
        for (int sd = 1; sd <= 2; sd++) begin
            void'($urandom(sd * 7919));
            for (int n = 0; n < 32; n++) begin
                code        = $urandom_range(15, 0);
                corriente   = 4'(code);
                corriente80 = 4'(code);
                tick();
                chk("rand_fn68", 16'(I), 16'(corr_setpoint(code)));
                chk("rand_fn80", 16'(I80), 16'(corr_setpoint(code, 80, 10)));
                chk("rand_tab68", 16'(I), 16'(exp68[code]));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
